fma_pipe_ctrl: RTL

- Pipeline sequencer for the single-precision FMA datapath.
- Accepts operations on a valid/ready handshake and drives per-stage register enables for the datapath.
- Carries per-operation sign metadata and a tag down the stages.
- Presents the two's-complement select (two_en) and the effective-subtract flag to the adder stage, aligned with that stage's data. Handles backpressure, bubbles and flush.

---
 rtl/fma_pipe_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fma_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// fma_pipe_ctrl
//
// Pipeline sequencer for the single-precision FMA datapath. Operations are
// accepted on a valid/ready handshake and marched through STAGES register
// stages. The controller produces the per-stage load enables for the datapath.
// It carries each operation's sign metadata {sign_P, sign_C} and its tag down
// the stages. It also presents the adder's complement select and
// effective-subtract flag, both taken from the metadata of stage ADD_STAGE so
// that they line up with that stage's data.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   flush        discard every in-flight operation at the next edge
//   in_valid     upstream operation available
//   in_ready     controller accepts an operation this cycle
//   in_sign_A    sign of multiplicand A
//   in_sign_B    sign of multiplier B
//   in_sign_C    sign of addend C
//   in_tag       opaque operation tag
//   stage_en     bit i = datapath stage i register load enable this cycle
//   stage_valid  bit i = stage i holds a live operation
//   two_en       complement select for the adder, {sign_C, sign_P}
//   eff_sub      effective subtraction (sign_P ^ sign_C)
//   out_valid    last stage holds a result
//   out_ready    downstream accepts the result
//   out_tag      tag of the result in the last stage
//   occupancy    number of live operations in the pipeline
// -----------------------------------------------------------------------------
module fma_pipe_ctrl #(
  parameter int STAGES    = 4,  // pipeline depth, 2..8
  parameter int ADD_STAGE = 1,  // stage feeding two_en/eff_sub, 0..STAGES-1
  parameter int TAG_W     = 4,  // operation tag width
  parameter int OCC_W     = 3   // occupancy width, must hold STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign_A,
  input  logic              in_sign_B,
  input  logic              in_sign_C,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_valid,
  output logic [1:0]        two_en,
  output logic              eff_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [OCC_W-1:0]  occupancy
);

  // Per-stage state: live flag, product sign, addend sign, tag.
  logic [STAGES-1:0]            v_q,   v_d;
  logic [STAGES-1:0]            sp_q,  sp_d;
  logic [STAGES-1:0]            sc_q,  sc_d;
  logic [STAGES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [OCC_W-1:0]             occ_q, occ_d;

  logic [STAGES-1:0] adv;      // stage i may be overwritten this cycle
  logic              accept;   // input handshake
  logic              retire;   // output handshake
  logic              sign_p;   // sign of the product A*B

  assign sign_p = in_sign_A ^ in_sign_B;

  // ---------------------------------------------------------------------------
  // Advance chain. A stage can take new data when it is empty, or when its
  // occupant leaves this cycle. The last stage drains into the downstream
  // consumer. This lets a stall compress bubbles: stages upstream of a hole
  // keep moving while the stalled tail holds.
  // ---------------------------------------------------------------------------
  always_comb begin : adv_chain
    logic chain;
    // NOTE: 'chain' is a combinational temporary read after it is written in
    // the same pass, so it uses blocking assignment; it is never a flop.
    adv   = '0;
    chain = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      chain  = chain | ~v_q[i];
      adv[i] = chain;
    end
  end

  // Flush blocks the input so that nothing enters in a cycle whose contents
  // are about to be discarded.
  assign in_ready = adv[0] & ~flush;
  assign accept   = in_valid & in_ready;
  assign retire   = v_q[STAGES-1] & out_ready;

  // ---------------------------------------------------------------------------
  // Load enables and next-state.
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned; that is what keeps this block free of latches.
    stage_en = '0;
    v_d      = v_q;
    sp_d     = sp_q;
    sc_d     = sc_q;
    tag_d    = tag_q;

    stage_en[0] = accept;
    for (int i = 1; i < STAGES; i++) begin
      stage_en[i] = v_q[i-1] & adv[i];
    end

    // A stage stays live if it loads or if it is held by a stall downstream.
    for (int i = 0; i < STAGES; i++) begin
      v_d[i] = stage_en[i] | (v_q[i] & ~adv[i]);
    end

    // Metadata moves only with a load enable and otherwise holds.
    if (stage_en[0]) begin
      sp_d[0]  = sign_p;
      sc_d[0]  = in_sign_C;
      tag_d[0] = in_tag;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (stage_en[i]) begin
        sp_d[i]  = sp_q[i-1];
        sc_d[i]  = sc_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end

    // An accept and a retire in the same cycle cancel out. A flush clears
    // everything. A retire during a flush still counts as consumed, since the
    // downstream side has already taken the result.
    occ_d = occ_q + OCC_W'(accept) - OCC_W'(retire);

    if (flush) begin
      v_d   = '0;
      occ_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so that every flop
    // samples its _d value from before the edge, whatever the statement order.
    if (rst) begin
      v_q   <= '0;
      // NOTE: the metadata and tag registers are cleared as well. Outputs
      // are then fully defined right after reset, and a stale tag cannot be
      // observed on out_tag.
      sp_q  <= '0;
      sc_q  <= '0;
      tag_q <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      sp_q  <= sp_d;
      sc_q  <= sc_d;
      tag_q <= tag_d;
      occ_q <= occ_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  // two_en = {sign_C, sign_P}: bit 0 complements the product path and bit 1
  // complements the addend path. Both are forced idle when the adder stage
  // holds a bubble, so the datapath never acts on stale signs.
  always_comb begin : adder_ctrl
    two_en  = 2'b00;
    eff_sub = 1'b0;
    if (v_q[ADD_STAGE]) begin
      two_en  = {sc_q[ADD_STAGE], sp_q[ADD_STAGE]};
      eff_sub = sp_q[ADD_STAGE] ^ sc_q[ADD_STAGE];
    end
  end

  assign stage_valid = v_q;
  assign out_valid   = v_q[STAGES-1];
  assign out_tag     = tag_q[STAGES-1];
  assign occupancy   = occ_q;

endmodule
